// File: rtl/lfsr_stream_checker.sv
// AXI-Stream sink that self-synchronises to an 8-bit Fibonacci LFSR stream
// and counts good/bad samples once locked.
module lfsr_stream_checker #(
    parameter int C_AXIS_DATA_WIDTH = 32,
    parameter int LOCK_COUNT        = 4,
    parameter int LOSS_COUNT        = 3,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [7:0]                   cfg_taps,
    input  logic                         clear,
    output logic                         locked,
    output logic [CNT_WIDTH-1:0]         sample_count,
    output logic [CNT_WIDTH-1:0]         error_count,
    output logic                         err_pulse
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);
    localparam logic [LW-1:0] LOSS_N = LW'(LOSS_COUNT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                 state_q;
    logic [7:0]             expected_q;
    logic [MW-1:0]          match_cnt_q;
    logic [LW-1:0]          miss_cnt_q;
    logic                   tready_q;
    logic                   locked_q;
    logic                   err_pulse_q;
    logic [CNT_WIDTH-1:0]   sample_count_q;
    logic [CNT_WIDTH-1:0]   error_count_q;

    logic [7:0]             sample_d;
    logic                   beat_d;
    logic                   good_d;
    logic [7:0]             seed_nxt_d;
    logic [7:0]             fly_nxt_d;
    logic [MW-1:0]          match_inc_d;
    logic [LW-1:0]          miss_inc_d;
    logic                   count_beat_d;
    logic                   count_err_d;

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] x, input logic [7:0] taps);
        return {^(x & taps), x[7:1]};
    endfunction

    always_comb begin
        sample_d     = s_axis_tdata[7:0];
        beat_d       = s_axis_tvalid & tready_q;
        good_d       = (sample_d == expected_q) &&
                       (s_axis_tdata[C_AXIS_DATA_WIDTH-1:8] == '0);
        seed_nxt_d   = lfsr_nxt(sample_d, cfg_taps);
        fly_nxt_d    = lfsr_nxt(expected_q, cfg_taps);
        match_inc_d  = match_cnt_q + 1'b1;
        miss_inc_d   = miss_cnt_q + 1'b1;
        count_beat_d = beat_d && (state_q == LOCKED);
        count_err_d  = count_beat_d && !good_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            tready_q    <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            tready_q    <= 1'b1;
            err_pulse_q <= 1'b0;
            if (beat_d) begin
                case (state_q)
                    HUNT: begin
                        // Zero is the LFSR lock-up value and cannot seed a prediction
                        if (sample_d != 8'h00) begin
                            expected_q  <= seed_nxt_d;
                            match_cnt_q <= '0;
                            state_q     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (good_d) begin
                            expected_q  <= seed_nxt_d;
                            match_cnt_q <= match_inc_d;
                            if (match_inc_d == LOCK_N) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                miss_cnt_q <= '0;
                            end
                        end else if (sample_d != 8'h00) begin
                            expected_q  <= seed_nxt_d;
                            match_cnt_q <= '0;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (good_d) begin
                            miss_cnt_q <= '0;
                            expected_q <= seed_nxt_d;
                        end else begin
                            // Flywheel on our own prediction so a lone bit error does not desync
                            err_pulse_q <= 1'b1;
                            expected_q  <= fly_nxt_d;
                            miss_cnt_q  <= miss_inc_d;
                            if (miss_inc_d == LOSS_N) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating counters; clear wins over a coincident increment
    always_ff @(posedge aclk) begin
        if (areset || clear) begin
            sample_count_q <= '0;
            error_count_q  <= '0;
        end else begin
            if (count_beat_d && !(&sample_count_q)) begin
                sample_count_q <= sample_count_q + 1'b1;
            end
            if (count_err_d && !(&error_count_q)) begin
                error_count_q <= error_count_q + 1'b1;
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign sample_count  = sample_count_q;
    assign error_count   = error_count_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed self-checking bench for lfsr_stream_checker (8-bit counters to reach saturation).
module tb_lfsr_stream_checker;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk;
    logic          areset;
    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tready;
    logic [7:0]    taps;
    logic          clear;
    logic          locked;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] error_count;
    logic          err_pulse;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] gen;
    logic [7:0] first5 [5];

    lfsr_stream_checker #(
        .C_AXIS_DATA_WIDTH(W),
        .LOCK_COUNT(4),
        .LOSS_COUNT(3),
        .CNT_WIDTH(CW)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .cfg_taps(taps),
        .clear(clear),
        .locked(locked),
        .sample_count(sample_count),
        .error_count(error_count),
        .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [7:0] ref_nxt(input logic [7:0] x, input logic [7:0] t);
        return {^(x & t), x[7:1]};
    endfunction

    // One beat: drive on the falling edge, release tvalid 1 ns after the capturing edge
    task automatic send(input logic [W-1:0] d, input bit gaps);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);
        tdata  = d;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic send_gen(input bit gaps);
        send({24'h0, gen}, gaps);
        gen = ref_nxt(gen, taps);
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        tdata  = '0;
        tvalid = 1'b0;
        taps   = 8'h87;
        clear  = 1'b0;
        first5[0] = 8'h01; first5[1] = 8'h80; first5[2] = 8'hC0;
        first5[3] = 8'hE0; first5[4] = 8'hF0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_tready", {31'h0, tready}, 32'h0);
        check_val("rst_locked", {31'h0, locked}, 32'h0);
        check_val("rst_samples", {24'h0, sample_count}, 32'h0);
        areset = 1'b0;
        @(negedge clk);
        check_val("tready_after_rst", {31'h0, tready}, 32'h1);

        // Test 1: lock on 01,80,C0,E0,F0 then 10 good beats
        for (int i = 0; i < 5; i++) begin
            send({24'h0, first5[i]}, 1'b0);
            if (i == 3) check_val("t1_not_locked_4", {31'h0, locked}, 32'h0);
        end
        check_val("t1_locked", {31'h0, locked}, 32'h1);
        check_val("t1_samples0", {24'h0, sample_count}, 32'h0);
        gen = 8'hF8;
        for (int i = 0; i < 10; i++) send_gen(1'b0);
        check_val("t1_samples10", {24'h0, sample_count}, 32'd10);
        check_val("t1_errors0", {24'h0, error_count}, 32'd0);

        // Test 2: single corrupt beat
        send({24'h0, gen ^ 8'h10}, 1'b0);
        gen = ref_nxt(gen, taps);
        check_val("t2_err_pulse", {31'h0, err_pulse}, 32'h1);
        check_val("t2_errors1", {24'h0, error_count}, 32'd1);
        check_val("t2_still_locked", {31'h0, locked}, 32'h1);
        send_gen(1'b0);
        check_val("t2_pulse_drop", {31'h0, err_pulse}, 32'h0);
        for (int i = 0; i < 3; i++) send_gen(1'b0);
        check_val("t2_errors_hold", {24'h0, error_count}, 32'd1);
        check_val("t2_samples15", {24'h0, sample_count}, 32'd15);

        // Test 3: three corrupt beats lose lock, five good beats regain it
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("t3_clear_samples", {24'h0, sample_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            send({24'h0, ~gen}, 1'b0);
            gen = ref_nxt(gen, taps);
            if (i == 1) check_val("t3_locked_after2", {31'h0, locked}, 32'h1);
        end
        check_val("t3_unlocked", {31'h0, locked}, 32'h0);
        check_val("t3_errors3", {24'h0, error_count}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            send_gen(1'b0);
            if (i == 3) check_val("t3_relock_pending", {31'h0, locked}, 32'h0);
        end
        check_val("t3_relocked", {31'h0, locked}, 32'h1);
        check_val("t3_samples3", {24'h0, sample_count}, 32'd3);

        // Test 4: zeros never lock; upper tdata bits make a beat bad
        do_reset();
        for (int i = 0; i < 4; i++) send(32'h0, 1'b0);
        check_val("t4_zero_unlocked", {31'h0, locked}, 32'h0);
        check_val("t4_zero_samples", {24'h0, sample_count}, 32'd0);
        check_val("t4_zero_errors", {24'h0, error_count}, 32'd0);
        gen = 8'h01;
        for (int i = 0; i < 5; i++) send_gen(1'b0);
        check_val("t4_locked", {31'h0, locked}, 32'h1);
        send({24'h1, gen}, 1'b0);
        gen = ref_nxt(gen, taps);
        check_val("t4_upper_err", {24'h0, error_count}, 32'd1);
        check_val("t4_upper_samples", {24'h0, sample_count}, 32'd1);

        // Test 5: clear coincident with a corrupt beat, then reset mid-stream
        @(negedge clk);
        clear = 1'b1;
        send({24'h0, gen ^ 8'h01}, 1'b0);
        gen = ref_nxt(gen, taps);
        check_val("t5_clear_samples", {24'h0, sample_count}, 32'd0);
        check_val("t5_clear_errors", {24'h0, error_count}, 32'd0);
        check_val("t5_clear_pulse", {31'h0, err_pulse}, 32'h1);
        check_val("t5_clear_locked", {31'h0, locked}, 32'h1);
        send_gen(1'b0);
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check_val("t5_rst_tready", {31'h0, tready}, 32'h0);
        check_val("t5_rst_locked", {31'h0, locked}, 32'h0);
        check_val("t5_rst_samples", {24'h0, sample_count}, 32'd0);
        areset = 1'b0;
        @(negedge clk);
        check_val("t5_tready_back", {31'h0, tready}, 32'h1);

        // Saturation: 300 counted beats on an 8-bit counter stop at 0xFF
        gen = 8'h01;
        for (int i = 0; i < 5; i++) send_gen(1'b0);
        for (int i = 0; i < 300; i++) send_gen(1'b0);
        check_val("sat_samples", {24'h0, sample_count}, 32'hFF);
        check_val("sat_errors", {24'h0, error_count}, 32'h0);

        // Test 6: taps 0xB8, seed 0xFF (FF,7F,BF,5F,2F,...) with random tvalid gaps
        do_reset();
        taps = 8'hB8;
        gen  = 8'hFF;
        check_val("t6_gen_step", {24'h0, ref_nxt(8'h7F, taps)}, 32'hBF);
        for (int i = 0; i < 5; i++) send_gen(1'b1);
        check_val("t6_locked", {31'h0, locked}, 32'h1);
        check_val("t6_samples0", {24'h0, sample_count}, 32'd0);
        for (int i = 0; i < 10; i++) send_gen(1'b1);
        check_val("t6_samples10", {24'h0, sample_count}, 32'd10);
        check_val("t6_errors0", {24'h0, error_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
